// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// default widths, FSM state encoding and winner encoding.
package mem_port_arbiter_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic WIN_FETCH = 1'b0;
   localparam logic WIN_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// the requester that did not win last time.
module rr_arbiter_2
   import mem_port_arbiter_pkg::*;
(
   input  logic       i_en,
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         if (i_req0 && i_req1) begin
            o_gnt = (i_last == WIN_FETCH) ? 2'b10 : 2'b01;
         end else begin
            o_gnt = {i_req1, i_req0};
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory with registered read; one access per two cycles when saturated.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_last;
   logic              r_we;
   logic [ADDR_W-3:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        w_gnt;
   logic              w_arb_en;
   logic              w_access;
   logic              w_resp;
   logic              w_unused;

   // Byte-lane bits are not part of the word address.
   assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

   // Arbitration happens in IDLE and RESP so a new access can start right
   // behind the response of the previous one.
   assign w_arb_en = !rst && ((r_state == ST_IDLE) || (r_state == ST_RESP));

   rr_arbiter_2 u_rr (
      .i_en   (w_arb_en),
      .i_req0 (i_req),
      .i_req1 (d_req),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (|w_gnt) w_state_nxt = ST_ACCESS;
         ST_ACCESS: w_state_nxt = ST_RESP;
         ST_RESP:   w_state_nxt = (|w_gnt) ? ST_ACCESS : ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Fetches are forced to reads regardless of the data port's write enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last  <= WIN_FETCH;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_gnt[1]) begin
         r_last  <= WIN_DATA;
         r_we    <= d_we;
         r_addr  <= d_addr[ADDR_W-1:2];
         r_wdata <= d_wdata;
      end else if (w_gnt[0]) begin
         r_last  <= WIN_FETCH;
         r_we    <= 1'b0;
         r_addr  <= i_addr[ADDR_W-1:2];
         r_wdata <= '0;
      end
   end

   assign w_access = !rst && (r_state == ST_ACCESS);
   assign w_resp   = !rst && (r_state == ST_RESP);

   assign i_gnt     = w_gnt[0];
   assign d_gnt     = w_gnt[1];
   assign mem_en    = w_access;
   assign mem_we    = w_access && r_we;
   assign mem_addr  = w_access ? r_addr : '0;
   assign mem_wdata = w_access ? r_wdata : '0;
   assign i_rvalid  = w_resp && (r_last == WIN_FETCH);
   assign d_rvalid  = w_resp && (r_last == WIN_DATA);
   assign rdata     = (w_resp && !r_we) ? mem_rdata : '0;
   assign busy      = !rst && (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory plus a transaction-level
// reference model, directed scenarios followed by randomized traffic.
module tb_mem_port_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Behavioural single-port memory with one-cycle registered read.
   logic [DATA_W-1:0] mem [64];
   logic              init_mem;

   function automatic logic [31:0] init_val(input int k);
      return 32'(k) * 32'h9E3779B1 + 32'h0BADF00D;
   endfunction

   always @(posedge clk) begin
      if (init_mem) begin
         for (int k = 0; k < 64; k++) mem[k] <= init_val(k);
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   // Reference model: cycle-indexed expectations of each transaction.
   int          n_cmp, n_err, cyc;
   int          next_ok, mem_c, rv_c;
   logic        last;
   logic        p_we;
   logic [5:0]  p_addr;
   logic [31:0] p_wd;
   logic        rv_who;
   logic [31:0] rv_data;
   logic [31:0] ref_mem [64];

   logic [1:0]  obs_gnt, obs_rv;
   logic        obs_busy, obs_men, obs_mwe;
   logic [5:0]  obs_maddr;
   logic [31:0] obs_rdata;

   logic [1:0]  g;
   logic        fa, dact, dwe_r, rr;
   logic [7:0]  fad, dad;
   logic [31:0] dwd_r;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic ir, input logic [7:0] ia, input logic dr,
                       input logic dwe, input logic [7:0] da, input logic [31:0] dwd,
                       input logic r, output logic [1:0] eg);
      logic allowed, acc, resp;
      rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
      allowed = !r && (cyc >= next_ok);
      eg = 2'b00;
      if (allowed) begin
         if (ir && dr) eg = last ? 2'b01 : 2'b10;
         else          eg = {dr, ir};
      end
      acc  = !r && (mem_c == cyc);
      resp = !r && (rv_c == cyc);
      @(negedge clk);
      chk("i_gnt", 32'(i_gnt), 32'(eg[0]));
      chk("d_gnt", 32'(d_gnt), 32'(eg[1]));
      chk("mem_en", 32'(mem_en), 32'(acc));
      chk("mem_we", 32'(mem_we), 32'(acc && p_we));
      if (acc || r) chk("mem_addr", 32'(mem_addr), r ? 32'd0 : 32'(p_addr));
      if ((acc && p_we) || r) chk("mem_wdata", mem_wdata, r ? 32'd0 : p_wd);
      chk("i_rvalid", 32'(i_rvalid), 32'(resp && !rv_who));
      chk("d_rvalid", 32'(d_rvalid), 32'(resp && rv_who));
      chk("rdata", rdata, resp ? rv_data : 32'd0);
      chk("busy", 32'(busy), 32'(acc || resp));
      obs_gnt = {d_gnt, i_gnt}; obs_rv = {d_rvalid, i_rvalid};
      obs_busy = busy; obs_men = mem_en; obs_mwe = mem_we;
      obs_maddr = mem_addr; obs_rdata = rdata;
      if (r) begin
         last = 1'b0; mem_c = -1; rv_c = -1; next_ok = cyc + 1;
      end else begin
         if (acc) begin
            if (p_we) begin ref_mem[p_addr] = p_wd; rv_data = 32'd0; end
            else rv_data = ref_mem[p_addr];
         end
         if (eg != 2'b00) begin
            last = eg[1]; p_we = eg[1] & dwe;
            p_addr = eg[1] ? da[7:2] : ia[7:2];
            p_wd = dwd; rv_who = eg[1];
            mem_c = cyc + 1; rv_c = cyc + 2; next_ok = cyc + 2;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      logic [1:0] gi;
      for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, gi);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0;
      next_ok = 0; mem_c = -1; rv_c = -1; last = 1'b0;
      p_we = 1'b0; p_addr = '0; p_wd = '0; rv_who = 1'b0; rv_data = '0;
      for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);
      init_mem = 1'b1; rst = 1'b1;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      @(posedge clk); #1;
      init_mem = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, g);
      chk("rst_busy", 32'(obs_busy), 32'd0);
      idle(1);

      // Single fetch from byte address 0x08.
      step(1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, g);
      chk("fetch_gnt", 32'(obs_gnt), 32'd1);
      idle(1);
      chk("fetch_maddr", 32'(obs_maddr), 32'd2);
      idle(1);
      chk("fetch_rv", 32'(obs_rv), 32'd1);
      chk("fetch_rdata", obs_rdata, init_val(2));

      // Data write then read back.
      step(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, g);
      chk("wr_gnt", 32'(obs_gnt), 32'd2);
      idle(1);
      chk("wr_mwe", 32'(obs_mwe), 32'd1);
      chk("wr_maddr", 32'(obs_maddr), 32'd4);
      idle(1);
      chk("wr_rv", 32'(obs_rv), 32'd2);
      chk("wr_rdata", obs_rdata, 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, g);
      idle(2);
      chk("rd_rdata", obs_rdata, 32'hDEADBEEF);

      // Tie after reset: d, i, d, i.
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, g);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 8'h04, 1'b1, 1'b0, 8'h20, 32'h0, 1'b0, g);
         chk("tie_gnt", 32'(obs_gnt), (k % 2 == 1) ? 32'd0 : ((k % 4 == 0) ? 32'd2 : 32'd1));
      end

      // Back-to-back data reads.
      idle(3);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 32'h0, 1'b0, g);
         chk("b2b_gnt", 32'(obs_gnt[1]), 32'(k % 2 == 0));
         if (k > 0) chk("b2b_busy", 32'(obs_busy), 32'd1);
      end

      // Reset during the access cycle.
      idle(3);
      step(1'b1, 8'h0C, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, g);
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, g);
      chk("rstacc_men", 32'(obs_men), 32'd0);
      idle(1);
      chk("rstacc_rv", 32'(obs_rv), 32'd0);
      chk("rstacc_busy", 32'(obs_busy), 32'd0);
      step(1'b1, 8'h0C, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, g);
      chk("rstacc_regnt", 32'(obs_gnt), 32'd1);
      idle(2);

      // Fetch while the data port shows d_we=1 without requesting.
      step(1'b1, 8'h14, 1'b0, 1'b1, 8'h24, 32'h55, 1'b0, g);
      idle(1);
      chk("fwe_men", 32'(obs_men), 32'd1);
      chk("fwe_mwe", 32'(obs_mwe), 32'd0);
      idle(2);

      // Randomized traffic with occasional drops and resets.
      fa = 0; dact = 0; fad = 0; dad = 0; dwe_r = 0; dwd_r = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!fa && $urandom_range(0, 2) == 0) begin fa = 1; fad = 8'($urandom); end
         else if (fa && $urandom_range(0, 15) == 0) fa = 0;
         if (!dact && $urandom_range(0, 2) == 0) begin
            dact = 1; dad = 8'($urandom); dwe_r = 1'($urandom); dwd_r = $urandom;
         end else if (dact && $urandom_range(0, 15) == 0) dact = 0;
         rr = ($urandom_range(0, 59) == 0);
         step(fa, fad, dact, dact ? dwe_r : 1'($urandom), dad, dwd_r, rr, g);
         if (g[0]) fa = 0;
         if (g[1]) dact = 0;
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
